i2c_master_ctrl: RTL and testbench

Single-byte I2C master controller that sequences the open-drain SCL/SDA bus pins used by the slave verification environment. It accepts one command at a time (7-bit address, R/W, one data byte) and generates START, address, ACK, data, ACK/NACK and STOP with a quarter-period bit engine. It supports slave clock stretching. It returns read data and ACK status on a one-cycle response strobe.

---
 rtl/i2c_master_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master controller.
// Sequences START, 7-bit address + R/W, address ACK, one data byte,
// data ACK (write) or master NACK (read), then STOP. Every bus phase is
// built from quarter-periods of CLK_DIV clocks; a slave holding SCL low
// while the master has released it freezes the quarter counter.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_drive_low,
    output logic       sda_drive_low,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK,
        STOP,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    qtr, qtr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic [7:0]    wdata_q, wdata_nx;
    logic          rw_q, rw_nx;
    logic [7:0]    rdata_nx;
    logic          nack_nx;
    logic [1:0]    drv_nx;
    logic          stretch;
    logic          qend;

    // Pin levels for a given phase: {scl_drive_low, sda_drive_low}.
    function automatic logic [1:0] drive(input state_t s, input logic [1:0] qq, input logic b);
        logic [1:0] d;
        d = 2'b00;
        case (s)
            START: begin
                case (qq)
                    2'd2:    d = 2'b01;
                    2'd3:    d = 2'b11;
                    default: d = 2'b00;
                endcase
            end
            ADDR, WRITE:                    d = {(qq < 2'd2), ~b};
            ADDR_ACK, WR_ACK, READ, RD_ACK: d = {(qq < 2'd2), 1'b0};
            STOP: begin
                case (qq)
                    2'd0:    d = 2'b11;
                    2'd3:    d = 2'b00;
                    default: d = 2'b01;
                endcase
            end
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    assign cmd_ready = (state == IDLE);
    // The slave is stretching when we released SCL but the bus is still low.
    assign stretch   = ~scl_drive_low & ~scl_in;
    assign qend      = (cnt == CNT_LAST) && !stretch;

    // Next-state, shift/sample datapath and next pin levels.
    always_comb begin
        state_nx   = state;
        qtr_nx     = qtr;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        wdata_nx   = wdata_q;
        rw_nx      = rw_q;
        rdata_nx   = rsp_rdata;
        nack_nx    = rsp_nack;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx   = START;
                    qtr_nx     = 2'd0;
                    cnt_nx     = '0;
                    bit_idx_nx = 3'd0;
                    shreg_nx   = {cmd_addr, cmd_rw};
                    wdata_nx   = cmd_wdata;
                    rw_nx      = cmd_rw;
                    rdata_nx   = 8'h00;
                    nack_nx    = 1'b0;
                end
            end
            DONE: state_nx = IDLE;
            default: begin
                if (!stretch) cnt_nx = qend ? '0 : cnt + CNT_ONE;
                if (qend) begin
                    qtr_nx = qtr + 2'd1;
                    case (state)
                        START: begin
                            if (qtr == 2'd3) begin
                                state_nx   = ADDR;
                                bit_idx_nx = 3'd0;
                            end
                        end
                        ADDR, WRITE: begin
                            if (qtr == 2'd3) begin
                                shreg_nx   = {shreg[6:0], 1'b0};
                                bit_idx_nx = bit_idx + 3'd1;
                                if (bit_idx == 3'd7)
                                    state_nx = (state == ADDR) ? ADDR_ACK : WR_ACK;
                            end
                        end
                        ADDR_ACK: begin
                            if (qtr == 2'd2) nack_nx = sda_in;
                            if (qtr == 2'd3) begin
                                bit_idx_nx = 3'd0;
                                shreg_nx   = wdata_q;
                                if (rsp_nack)  state_nx = STOP;
                                else if (rw_q) state_nx = READ;
                                else           state_nx = WRITE;
                            end
                        end
                        WR_ACK: begin
                            if (qtr == 2'd2) nack_nx = sda_in;
                            if (qtr == 2'd3) state_nx = STOP;
                        end
                        READ: begin
                            if (qtr == 2'd2) rdata_nx = {rsp_rdata[6:0], sda_in};
                            if (qtr == 2'd3) begin
                                bit_idx_nx = bit_idx + 3'd1;
                                if (bit_idx == 3'd7) state_nx = RD_ACK;
                            end
                        end
                        RD_ACK: begin
                            if (qtr == 2'd3) state_nx = STOP;
                        end
                        STOP: begin
                            if (qtr == 2'd3) state_nx = DONE;
                        end
                        default: state_nx = IDLE;
                    endcase
                end
            end
        endcase
        drv_nx = drive(state_nx, qtr_nx, shreg_nx[7]);
    end

    // State and registered outputs; reset releases both bus lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            qtr           <= 2'd0;
            cnt           <= '0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            wdata_q       <= 8'h00;
            rw_q          <= 1'b0;
            rsp_rdata     <= 8'h00;
            rsp_nack      <= 1'b0;
            rsp_valid     <= 1'b0;
            busy          <= 1'b0;
            scl_drive_low <= 1'b0;
            sda_drive_low <= 1'b0;
        end else begin
            state         <= state_nx;
            qtr           <= qtr_nx;
            cnt           <= cnt_nx;
            bit_idx       <= bit_idx_nx;
            shreg         <= shreg_nx;
            wdata_q       <= wdata_nx;
            rw_q          <= rw_nx;
            rsp_rdata     <= rdata_nx;
            rsp_nack      <= nack_nx;
            rsp_valid     <= (state_nx == DONE);
            busy          <= (state_nx != IDLE);
            scl_drive_low <= drv_nx[1];
            sda_drive_low <= drv_nx[0];
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bus-level slave model decodes START/STOP and
// bytes from the pin activity, answers ACKs, supplies read data and can
// stretch SCL. Expected results come from transaction-level rules.
module tb_i2c_master_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_rdata;
    logic       scl_drive_low, sda_drive_low, scl_in, sda_in;

    int checks   = 0;
    int failures = 0;

    // slave model state
    logic       slv_sda_low, slv_scl_low;
    bit         cfg_ack_a, cfg_ack_d, cfg_stretch;
    logic [7:0] cfg_rbyte;
    int         bitcnt, byte_no, stops, hold_rem;
    logic [7:0] cur;
    logic [7:0] cap [2];
    logic       ackbit [2];
    bit         in_txn, p_scl, p_sda, slv_rw;

    always #5 clk = ~clk;

    assign scl_in = ~scl_drive_low & ~slv_scl_low;
    assign sda_in = ~sda_drive_low & ~slv_sda_low;

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low),
        .scl_in(scl_in), .sda_in(sda_in)
    );

    // Bus-level slave: watches master pin edges at every falling clock edge.
    initial begin
        slv_sda_low = 1'b0; slv_scl_low = 1'b0; stops = 0; in_txn = 0;
        p_scl = 1; p_sda = 1; bitcnt = 0; byte_no = 0; cur = 8'h00; hold_rem = 0; slv_rw = 0;
        cap[0] = 8'h00; cap[1] = 8'h00; ackbit[0] = 1'b1; ackbit[1] = 1'b1;
        forever begin
            bit scl_m, sda_m;
            @(negedge clk);
            scl_m = !scl_drive_low;
            sda_m = !sda_drive_low;
            if (reset) begin
                slv_sda_low = 1'b0; slv_scl_low = 1'b0; in_txn = 0; hold_rem = 0;
            end else begin
                if (slv_scl_low) begin
                    hold_rem--;
                    if (hold_rem == 0) slv_scl_low = 1'b0;
                end
                if (p_scl && scl_m && p_sda && !sda_m) begin
                    in_txn = 1; bitcnt = 0; byte_no = 0; cur = 8'h00;
                end else if (p_scl && scl_m && !p_sda && sda_m) begin
                    stops++; in_txn = 0; slv_sda_low = 1'b0;
                end else if (in_txn && !p_scl && scl_m) begin
                    if (bitcnt < 8) begin
                        cur = {cur[6:0], sda_in};
                        if (byte_no == 0 && bitcnt == 3 && cfg_stretch) begin
                            slv_scl_low = 1'b1; hold_rem = 10;
                        end
                        bitcnt++;
                    end else begin
                        if (byte_no < 2) ackbit[byte_no] = sda_in;
                        bitcnt = 9;
                    end
                end else if (in_txn && p_scl && !scl_m) begin
                    if (bitcnt == 9) begin
                        slv_sda_low = 1'b0;
                        if (byte_no < 2) cap[byte_no] = cur;
                        byte_no++; bitcnt = 0; cur = 8'h00;
                    end else if (bitcnt == 8) begin
                        if (byte_no == 0) begin
                            slv_rw = cur[0]; slv_sda_low = cfg_ack_a;
                        end else if (!slv_rw) slv_sda_low = cfg_ack_d;
                        else slv_sda_low = 1'b0;
                    end
                    if (byte_no == 1 && slv_rw && bitcnt < 8) slv_sda_low = !cfg_rbyte[7-bitcnt];
                end
            end
            p_scl = scl_m;
            p_sda = sda_m;
        end
    end

    // Transaction-level latency: quarters on the bus times D, plus the DONE cycle.
    function automatic int model_latency(input bit ack_a, input bit stretch);
        int q;
        q = 4 + 32 + 4 + 4;
        if (ack_a) q += 36;
        return q * D + 1 + (stretch ? 10 : 0);
    endfunction

    // Issue one command and collect what the DUT reports (no comparisons here).
    task automatic run_txn(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                           output int lat, output logic nk, output logic [7:0] rd,
                           output bit busy_ok, output bit pulse_ok);
        int n;
        bit got;
        @(negedge clk);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_addr = ~a; cmd_wdata = ~wd;
        lat = 1; busy_ok = 1; got = 0; nk = 1'bx; rd = 8'hxx;
        while (!got && lat < 3000) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (rsp_valid === 1'b1) begin got = 1; nk = rsp_nack; rd = rsp_rdata; end
            else begin @(negedge clk); lat++; end
        end
        if (!got) lat = -1;
        @(negedge clk);
        pulse_ok = (rsp_valid === 1'b0) && (busy === 1'b0) && (cmd_ready === 1'b1) &&
                   (rsp_nack === nk) && (rsp_rdata === rd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({scl_drive_low, sda_drive_low, rsp_valid, rsp_nack, busy, cmd_ready, rsp_rdata} !== {6'b000001, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {scl_drive_low, sda_drive_low, rsp_valid, rsp_nack, busy, cmd_ready, rsp_rdata}, {6'b000001, 8'h00});
        end
        @(negedge clk); @(negedge clk); #2 reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int lat, s0; logic nk; logic [7:0] rd; bit bok, pok;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 0; s0 = stops;
        run_txn(1'b0, 7'h50, 8'hA5, lat, nk, rd, bok, pok);
        checks++; if (lat !== model_latency(1, 0)) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, model_latency(1, 0)); end
        checks++; if ({nk, rd} !== 9'h000) begin failures++; $display("FAIL wr_rsp got nack=%b rdata=%h exp nack=0 rdata=00", nk, rd); end
        checks++; if (cap[0] !== 8'hA0 || cap[1] !== 8'hA5) begin failures++; $display("FAIL wr_bus_bytes got=%h/%h exp=a0/a5", cap[0], cap[1]); end
        checks++; if (ackbit[0] !== 1'b0 || ackbit[1] !== 1'b0) begin failures++; $display("FAIL wr_ack_bits got=%b%b exp=00", ackbit[0], ackbit[1]); end
        checks++; if (stops !== s0 + 1) begin failures++; $display("FAIL wr_stop got=%0d exp=%0d", stops - s0, 1); end
        checks++; if (!(bok && pok)) begin failures++; $display("FAIL wr_busy_pulse got busy_ok=%0d pulse_ok=%0d exp=1/1", bok, pok); end
    endtask

    task automatic test_addr_nack();
        int lat, s0; logic nk; logic [7:0] rd; bit bok, pok;
        cfg_ack_a = 0; cfg_ack_d = 1; cfg_stretch = 0; s0 = stops;
        run_txn(1'b0, 7'h23, 8'h5A, lat, nk, rd, bok, pok);
        checks++; if (lat !== model_latency(0, 0)) begin failures++; $display("FAIL nack_latency got=%0d exp=%0d", lat, model_latency(0, 0)); end
        checks++; if (nk !== 1'b1) begin failures++; $display("FAIL nack_flag got=%b exp=1", nk); end
        checks++; if (cap[0] !== 8'h46) begin failures++; $display("FAIL nack_addr_byte got=%h exp=46", cap[0]); end
        checks++; if (byte_no !== 1 || stops !== s0 + 1) begin failures++; $display("FAIL nack_no_data got bytes=%0d stops=%0d exp bytes=1 stops=1", byte_no, stops - s0); end
        checks++; if (!(bok && pok)) begin failures++; $display("FAIL nack_busy_pulse got busy_ok=%0d pulse_ok=%0d exp=1/1", bok, pok); end
    endtask

    task automatic test_read();
        int lat; logic nk; logic [7:0] rd; bit bok, pok;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 0; cfg_rbyte = 8'h3C;
        run_txn(1'b1, 7'h50, 8'hFF, lat, nk, rd, bok, pok);
        checks++; if (lat !== model_latency(1, 0)) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, model_latency(1, 0)); end
        checks++; if ({nk, rd} !== {1'b0, 8'h3C}) begin failures++; $display("FAIL rd_rsp got nack=%b rdata=%h exp nack=0 rdata=3c", nk, rd); end
        checks++; if (cap[0] !== 8'hA1) begin failures++; $display("FAIL rd_addr_byte got=%h exp=a1", cap[0]); end
        checks++; if (ackbit[1] !== 1'b1) begin failures++; $display("FAIL rd_master_nack got sda=%b exp=1", ackbit[1]); end
        checks++; if (!(bok && pok)) begin failures++; $display("FAIL rd_busy_pulse got busy_ok=%0d pulse_ok=%0d exp=1/1", bok, pok); end
    endtask

    task automatic test_stretch();
        int lat; logic nk; logic [7:0] rd; bit bok, pok;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 1;
        run_txn(1'b0, 7'h50, 8'h5A, lat, nk, rd, bok, pok);
        cfg_stretch = 0;
        checks++; if (lat !== model_latency(1, 1)) begin failures++; $display("FAIL stretch_latency got=%0d exp=%0d", lat, model_latency(1, 1)); end
        checks++; if (cap[0] !== 8'hA0 || cap[1] !== 8'h5A) begin failures++; $display("FAIL stretch_bytes got=%h/%h exp=a0/5a", cap[0], cap[1]); end
        checks++; if (nk !== 1'b0) begin failures++; $display("FAIL stretch_nack got=%b exp=0", nk); end
    endtask

    task automatic test_reset_mid();
        int n, lat; logic nk; logic [7:0] rd; bit bok, pok, seen;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 0;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_addr = 7'h50; cmd_wdata = 8'h81; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(in_txn && byte_no == 0 && bitcnt == 5) && n < 1000) begin @(negedge clk); n++; end
        repeat (2 * D + 1) @(negedge clk);
        checks++; if (n >= 1000 || {scl_drive_low, sda_drive_low} !== 2'b11) begin failures++; $display("FAIL rstmid_bit5_lines got=%b exp=11", {scl_drive_low, sda_drive_low}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({scl_drive_low, sda_drive_low, busy, rsp_valid} !== 4'b0000) begin failures++; $display("FAIL rstmid_release got=%b exp=0000", {scl_drive_low, sda_drive_low, busy, rsp_valid}); end
        @(negedge clk); @(negedge clk); #2 reset = 1'b0;
        seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || scl_drive_low !== 1'b0) seen = 1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rstmid_quiet got activity=1 exp=0"); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
        run_txn(1'b0, 7'h11, 8'hC3, lat, nk, rd, bok, pok);
        checks++; if (lat !== model_latency(1, 0) || nk !== 1'b0) begin failures++; $display("FAIL rstmid_next_txn got lat=%0d nack=%b exp lat=%0d nack=0", lat, nk, model_latency(1, 0)); end
        checks++; if (cap[0] !== 8'h22 || cap[1] !== 8'hC3) begin failures++; $display("FAIL rstmid_next_bytes got=%h/%h exp=22/c3", cap[0], cap[1]); end
    endtask

    task automatic test_back_to_back();
        int t, nacc, nrsp;
        int acc_t [3];
        int rsp_t [2];
        bit busy_at_acc2, acc;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 0; cfg_rbyte = 8'h96;
        acc_t[0] = -1; acc_t[1] = -1; acc_t[2] = -1; rsp_t[0] = -1; rsp_t[1] = -1;
        nacc = 0; nrsp = 0; t = 0; busy_at_acc2 = 1;
        @(negedge clk);
        cmd_rw = 1'b0; cmd_addr = 7'h3B; cmd_wdata = 8'h0F; cmd_valid = 1'b1;
        while (nrsp < 2 && t < 3000) begin
            acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
            if (rsp_valid === 1'b1) begin rsp_t[nrsp] = t; nrsp++; end
            if (acc) begin
                if (nacc < 3) acc_t[nacc] = t;
                if (nacc == 1) busy_at_acc2 = busy;
                nacc++;
            end
            if (nrsp < 2) begin
                @(posedge clk); #1;
                if (acc && nacc == 1) begin cmd_rw = 1'b1; cmd_addr = 7'h2A; cmd_wdata = 8'h00; end
                else if (acc) cmd_valid = 1'b0;
                @(negedge clk); t++;
            end
        end
        cmd_valid = 1'b0;
        checks++; if (nrsp !== 2 || nacc !== 2) begin failures++; $display("FAIL b2b_counts got rsp=%0d acc=%0d exp=2/2", nrsp, nacc); end
        checks++; if (acc_t[1] !== rsp_t[0] + 1) begin failures++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_t[1], rsp_t[0] + 1); end
        checks++; if (rsp_t[0] - acc_t[0] !== model_latency(1, 0)) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=%0d", rsp_t[0] - acc_t[0], model_latency(1, 0)); end
        checks++; if (rsp_t[1] - acc_t[1] !== model_latency(1, 0)) begin failures++; $display("FAIL b2b_lat2 got=%0d exp=%0d", rsp_t[1] - acc_t[1], model_latency(1, 0)); end
        checks++; if (busy_at_acc2 !== 1'b0) begin failures++; $display("FAIL b2b_busy_overlap got=%b exp=0", busy_at_acc2); end
        checks++; if ({rsp_nack, rsp_rdata} !== {1'b0, 8'h96} || cap[0] !== 8'h55) begin failures++; $display("FAIL b2b_second_rsp got nack=%b rdata=%h addr=%h exp 0/96/55", rsp_nack, rsp_rdata, cap[0]); end
    endtask

    task automatic test_random();
        int lat, s0; logic nk; logic [7:0] rd; bit bok, pok;
        logic rw; logic [6:0] a; logic [7:0] wd, rb, exp_rd; logic exp_nk;
        for (int i = 0; i < 6; i++) begin
            rw = 1'($urandom_range(0, 1)); a = 7'($urandom); wd = 8'($urandom); rb = 8'($urandom);
            cfg_ack_a = ($urandom_range(0, 3) != 0);
            cfg_ack_d = ($urandom_range(0, 3) != 0);
            cfg_rbyte = rb; cfg_stretch = 0; s0 = stops;
            run_txn(rw, a, wd, lat, nk, rd, bok, pok);
            exp_nk = !cfg_ack_a || (!rw && !cfg_ack_d);
            exp_rd = (rw && cfg_ack_a) ? rb : 8'h00;
            checks++; if (lat !== model_latency(cfg_ack_a, 0)) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, model_latency(cfg_ack_a, 0)); end
            checks++; if ({nk, rd} !== {exp_nk, exp_rd}) begin failures++; $display("FAIL rand%0d_rsp got nack=%b rdata=%h exp nack=%b rdata=%h", i, nk, rd, exp_nk, exp_rd); end
            checks++; if (cap[0] !== {a, rw}) begin failures++; $display("FAIL rand%0d_addr_byte got=%h exp=%h", i, cap[0], {a, rw}); end
            if (cfg_ack_a) begin
                checks++; if (cap[1] !== (rw ? rb : wd)) begin failures++; $display("FAIL rand%0d_data_byte got=%h exp=%h", i, cap[1], rw ? rb : wd); end
            end
            checks++; if (stops !== s0 + 1 || !(bok && pok)) begin failures++; $display("FAIL rand%0d_stop_pulse got stops=%0d busy_ok=%0d pulse_ok=%0d exp 1/1/1", i, stops - s0, bok, pok); end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'h00; cmd_wdata = 8'h00;
        cfg_ack_a = 1; cfg_ack_d = 1; cfg_stretch = 0; cfg_rbyte = 8'h00;
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
